alu_vector_gen: RTL and testbench
=================================

Name: alu_vector_gen

Overview:
- Synthesizable stimulus and expected-response generator for the parameterized 4-op ALU.
- Produces packed test vectors `{alucontrol, a, b, result_exp, flags_exp}` in the same bit layout the ALU bench consumes.
- Each vector is emitted over a valid/ready stream, so a checker or a file writer can consume it.
- Two modes:
  - exhaustive: every op/a/b combination;
  - random: a fixed count of LFSR-driven vectors.

Parameters:
- WIDTH, 3, operand/result width; legal range 1..32.
- VEC_LEN, 2+3*WIDTH+4, packed vector width; derived, not overridden.
- NUM_RANDOM, 64, number of vectors emitted in random mode; must be at least 1.
- SEED_A, 32'h1, nonzero seed for the a-field LFSR.
- SEED_B, 32'h2, nonzero seed for the b-field LFSR.
- SEED_OP, 32'h3, nonzero seed for the op-field LFSR.

Ports:
- clk  in  1  clock; everything on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- mode  in  1  0=exhaustive, 1=random; sampled together with start.
- vec_valid  out  1  vec_data holds a valid vector.
- vec_ready  in  1  consumer accepts the vector this cycle.
- vec_data  out  VEC_LEN  {op[1:0], a, b, result_exp, flags_exp[3:0]}, MSB first.
- vec_count  out  32  number of vectors transferred in the current run.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Op encoding: ADD=00, SUB=01, AND=10, OR=11.
- flags_exp = {N, Z, C, V}:
  - N = result_exp[WIDTH-1];
  - Z = (result_exp == 0);
  - ADD: sum = a + b computed at WIDTH+1 bits; C = sum[WIDTH]; V = (a and b have the same sign) and (result sign differs from a).
  - SUB: computed as a + ~b + 1 at WIDTH+1 bits; C = carry out of that sum; V = (a and b have different signs) and (result sign differs from a).
  - AND/OR: C = 0, V = 0.
- All arithmetic is modulo 2^WIDTH.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → RUN. Latch mode. Clear vec_count and the index. Load the LFSRs with their seeds.
  - RUN: vec_valid=1 on the first RUN cycle, with vector 0 registered. Latency from the start edge to valid is 1 cycle.
  - RUN transfer: a transfer occurs when vec_valid && vec_ready. On a transfer, vec_count increments and the next vector is registered on the same edge. Back-to-back transfers are supported at 1 vector per cycle.
  - RUN stall: while vec_valid && !vec_ready, vec_data is held bit-stable and vec_valid stays 1.
  - RUN exit: the transfer of the last vector → DONE. In the next cycle vec_valid=0 and done=1.
  - DONE: done is held. start=1 → RUN as from IDLE (restart with reseeded LFSRs).
  - start is ignored while in RUN.
- Exhaustive mode:
  - Index counter {op, a, b} of width 2+2*WIDTH, starting at 0 and incrementing by 1 per transfer.
  - Total vectors = 4 << (2*WIDTH); the last vector is index all-ones.
  - Exhaustive mode is legal only for WIDTH ≤ 12. For WIDTH > 12, a latched mode=0 is forced to random.
- Random mode:
  - Three 32-bit Galois LFSRs, polynomial x^32+x^22+x^2+x+1.
  - Fields: op = op-LFSR[1:0], a = a-LFSR[WIDTH-1:0], b = b-LFSR[WIDTH-1:0].
  - All three LFSRs advance once per transfer only; stalls do not advance them.
  - The run ends after NUM_RANDOM transfers.
- Reset, at any time including mid-run, gives state=IDLE and these outputs the next cycle:
  - vec_valid=0, vec_data=0, vec_count=0, busy=0, done=0.
- vec_data and the status outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Exhaustive first vectors (WIDTH=3):
  - reset, then start=1 with mode=0 and vec_ready=1;
  - → 1 cycle later vec_valid=1 and vec_data=15'b00_000_000_000_0100;
  - → the next vector is 15'b00_000_001_001_0000.
- Exhaustive flag corners (WIDTH=3):
  - index 65 (SUB 0-1) → result 111, flags 1000;
  - ADD 3+1 → 100, flags 1001;
  - SUB 3-3 → 000, flags 0110;
  - index 255 → 15'b11_111_111_111_1000;
  - → done=1 with vec_count=256 on the cycle after the last transfer.
- Backpressure:
  - vec_ready=0 for 5 cycles mid-run → vec_data stable and vec_valid=1 throughout;
  - vec_count unchanged during the stall;
  - after ready resumes, the sequence continues identical to a no-stall run.
- Random mode:
  - start with mode=1 → exactly 64 transfers, then done=1;
  - a restart from DONE reproduces a bit-identical sequence;
  - a scoreboard recomputes result_exp/flags_exp for every vector and finds 0 mismatches.
- Reset mid-run:
  - assert reset at vector 10 → the next cycle vec_valid=0, vec_count=0, busy=0, done=0;
  - start=1 again → vector 0 is identical to the first run's vector 0.
- Start ignored:
  - pulse start during RUN with mode toggled → no restart, no mode change, and vec_count continues monotonically.

Source files
------------

// File: rtl/alu_vector_gen.sv
// Stimulus and expected-response generator for the 4-op ALU: emits packed
// {op, a, b, result_exp, flags_exp} vectors over a valid/ready stream.
module alu_vector_gen #(
    parameter int          WIDTH      = 3,
    parameter int          NUM_RANDOM = 64,
    parameter logic [31:0] SEED_A     = 32'h1,
    parameter logic [31:0] SEED_B     = 32'h2,
    parameter logic [31:0] SEED_OP    = 32'h3,
    localparam int         VEC_LEN    = 2 + 3*WIDTH + 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    output logic               vec_valid,
    input  logic               vec_ready,
    output logic [VEC_LEN-1:0] vec_data,
    output logic [31:0]        vec_count,
    output logic               busy,
    output logic               done
);

    localparam int          IDX_W      = 2 + 2*WIDTH;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic        FORCE_RAND = (WIDTH > 12);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [31:0] lfsrStep(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Golden ALU behaviour; flags are {N, Z, C, V}.
    function automatic logic [VEC_LEN-1:0] makeVec(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        logic             n;
        logic             z;
        sum = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            2'b00: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            2'b01: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            2'b10:   res = a & b;
            default: res = a | b;
        endcase
        n = res[WIDTH-1];
        z = (res == '0);
        return {op, a, b, res, n, z, c, v};
    endfunction

    state_t             state_q, state_d;
    logic               rand_q, rand_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        lfsrA_q, lfsrA_d;
    logic [31:0]        lfsrB_q, lfsrB_d;
    logic [31:0]        lfsrOp_q, lfsrOp_d;
    logic [31:0]        count_q, count_d;
    logic               valid_q, valid_d;
    logic [VEC_LEN-1:0] data_q, data_d;

    logic               xfer;
    logic               lastVec;
    logic [IDX_W-1:0]   idxNext;
    logic [31:0]        lfsrANext;
    logic [31:0]        lfsrBNext;
    logic [31:0]        lfsrOpNext;

    assign xfer       = valid_q && vec_ready;
    assign lastVec    = rand_q ? (count_q == 32'(NUM_RANDOM - 1)) : (idx_q == '1);
    assign idxNext    = idx_q + IDX_W'(1);
    assign lfsrANext  = lfsrStep(lfsrA_q);
    assign lfsrBNext  = lfsrStep(lfsrB_q);
    assign lfsrOpNext = lfsrStep(lfsrOp_q);

    always_comb begin
        state_d  = state_q;
        rand_d   = rand_q;
        idx_d    = idx_q;
        lfsrA_d  = lfsrA_q;
        lfsrB_d  = lfsrB_q;
        lfsrOp_d = lfsrOp_q;
        count_d  = count_q;
        valid_d  = valid_q;
        data_d   = data_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    rand_d   = mode || FORCE_RAND;
                    idx_d    = '0;
                    lfsrA_d  = SEED_A;
                    lfsrB_d  = SEED_B;
                    lfsrOp_d = SEED_OP;
                    count_d  = '0;
                    valid_d  = 1'b1;
                    data_d   = rand_d ? makeVec(SEED_OP[1:0], SEED_A[WIDTH-1:0], SEED_B[WIDTH-1:0])
                                      : makeVec(2'b00, '0, '0);
                end
            end
            RUN: begin
                // Stalls leave every piece of generator state untouched.
                if (xfer) begin
                    count_d = count_q + 32'd1;
                    if (lastVec) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                    end else begin
                        idx_d    = idxNext;
                        lfsrA_d  = lfsrANext;
                        lfsrB_d  = lfsrBNext;
                        lfsrOp_d = lfsrOpNext;
                        data_d   = rand_q ? makeVec(lfsrOpNext[1:0], lfsrANext[WIDTH-1:0], lfsrBNext[WIDTH-1:0])
                                          : makeVec(idxNext[IDX_W-1 -: 2], idxNext[2*WIDTH-1 -: WIDTH],
                                                    idxNext[WIDTH-1:0]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rand_q   <= 1'b0;
            idx_q    <= '0;
            lfsrA_q  <= SEED_A;
            lfsrB_q  <= SEED_B;
            lfsrOp_q <= SEED_OP;
            count_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rand_q   <= rand_d;
            idx_q    <= idx_d;
            lfsrA_q  <= lfsrA_d;
            lfsrB_q  <= lfsrB_d;
            lfsrOp_q <= lfsrOp_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign vec_valid = valid_q;
    assign vec_data  = data_q;
    assign vec_count = count_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_alu_vector_gen.sv
// Bench for alu_vector_gen: exhaustive and random runs checked against an
// arithmetic reference model, with backpressure, restart and mid-run reset.
module tb_alu_vector_gen;

    localparam int W    = 3;
    localparam int VL   = 2 + 3*W + 4;
    localparam int NRND = 64;
    localparam int NEXH = 4 << (2*W);

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic          vecReady;
    logic          vecValid;
    logic [VL-1:0] vecData;
    logic [31:0]   vecCount;
    logic          busy;
    logic          done;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [VL-1:0] exhQ[$];
    logic [VL-1:0] rndQ[$];

    alu_vector_gen #(.WIDTH(W), .NUM_RANDOM(NRND)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .vec_valid (vecValid),
        .vec_ready (vecReady),
        .vec_data  (vecData),
        .vec_count (vecCount),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: plain integer arithmetic with signed range checks for V.
    function automatic logic [VL-1:0] refVec(input int op, input int a, input int b);
        int m;
        int half;
        int r;
        int sa;
        int sb;
        int sr;
        logic c;
        logic v;
        logic [1:0]   opv;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] rv;
        m    = 1 << W;
        half = 1 << (W - 1);
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            0: begin
                r  = a + b;
                c  = (r >= m);
                sr = sa + sb;
                v  = (sr < -half) || (sr >= half);
            end
            1: begin
                r  = a - b;
                c  = (a >= b);
                sr = sa - sb;
                v  = (sr < -half) || (sr >= half);
            end
            2:       r = a & b;
            default: r = a | b;
        endcase
        r   = ((r % m) + m) % m;
        opv = 2'(op);
        av  = W'(a);
        bv  = W'(b);
        rv  = W'(r);
        return {opv, av, bv, rv, (r >= half), (r == 0), c, v};
    endfunction

    function automatic logic [31:0] lfsrNext(input logic [31:0] s);
        logic [31:0] poly;
        poly = 32'h8020_0003;
        return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic startIn, input logic modeIn, input logic readyIn);
        start    = startIn;
        mode     = modeIn;
        vecReady = readyIn;
        tick();
        start = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, vecValid, 1'b0);
        checkOutput({tag, "_data"},  vecData,  '0);
        checkOutput({tag, "_count"}, vecCount, 0);
        checkOutput({tag, "_busy"},  busy,     1'b0);
        checkOutput({tag, "_done"},  done,     1'b0);
    endtask

    task automatic checkDoneOutputs(input string tag, input int n);
        checkOutput({tag, "_valid"}, vecValid, 1'b0);
        checkOutput({tag, "_done"},  done,     1'b1);
        checkOutput({tag, "_busy"},  busy,     1'b0);
        checkOutput({tag, "_count"}, vecCount, n);
    endtask

    // Walks one run already started; stallAt injects a 5-cycle ready gap and
    // pulseAt fires start with the opposite mode in the middle of the run.
    task automatic runVectors(input bit isRand, input int n, input bit randReady,
                              input int stallAt, input int pulseAt);
        int k;
        int cycles;
        int stallLeft;
        logic [VL-1:0] expVec;
        k         = 0;
        cycles    = 0;
        stallLeft = 5;
        while (k < n && cycles < 8*n + 64) begin
            expVec = isRand ? rndQ[k] : exhQ[k];
            checkOutput("run_valid", vecValid, 1'b1);
            checkOutput("run_busy",  busy,     1'b1);
            checkOutput("run_data",  vecData,  expVec);
            checkOutput("run_count", vecCount, k);
            if (!isRand) begin
                case (k)
                    0:   checkOutput("exh_vec0",   vecData, 15'b00_000_000_000_0100);
                    1:   checkOutput("exh_vec1",   vecData, 15'b00_000_001_001_0000);
                    25:  checkOutput("exh_add3p1", vecData, 15'b00_011_001_100_1001);
                    65:  checkOutput("exh_sub0m1", vecData, 15'b01_000_001_111_1000);
                    91:  checkOutput("exh_sub3m3", vecData, 15'b01_011_011_000_0110);
                    255: checkOutput("exh_last",   vecData, 15'b11_111_111_111_1000);
                    default: ;
                endcase
            end
            if (k == stallAt && stallLeft > 0) begin
                vecReady = 1'b0;
                stallLeft--;
            end else if (randReady) begin
                vecReady = ($urandom_range(0, 3) != 0);
            end else begin
                vecReady = 1'b1;
            end
            if (k == pulseAt && cycles < 8*n) begin
                start = 1'b1;
                mode  = ~isRand;
                pulseAt = -1;
            end
            tick();
            start = 1'b0;
            mode  = isRand;
            cycles++;
            if (vecReady) k++;
        end
        if (k < n) checkOutput("run_timeout", k, n);
        vecReady = 1'b1;
    endtask

    initial begin
        logic [31:0] sa;
        logic [31:0] sb;
        logic [31:0] so;
        start    = 1'b0;
        mode     = 1'b0;
        vecReady = 1'b0;
        reset    = 1'b1;

        for (int i = 0; i < NEXH; i++)
            exhQ.push_back(refVec(i >> (2*W), (i >> W) & ((1 << W) - 1), i & ((1 << W) - 1)));
        sa = 32'h1;
        sb = 32'h2;
        so = 32'h3;
        for (int i = 0; i < NRND; i++) begin
            rndQ.push_back(refVec(int'(so & 32'h3), int'(sa & ((1 << W) - 1)), int'(sb & ((1 << W) - 1))));
            sa = lfsrNext(sa);
            sb = lfsrNext(sb);
            so = lfsrNext(so);
        end

        tick();
        tick();
        checkIdleOutputs("reset");
        reset = 1'b0;

        $display("[TB] exhaustive run with stall and ignored start");
        applyStimulus(1'b1, 1'b0, 1'b1);
        runVectors(1'b0, NEXH, 1'b0, 100, 50);
        checkDoneOutputs("exh_done", NEXH);

        $display("[TB] random run, random backpressure");
        applyStimulus(1'b1, 1'b1, 1'b1);
        runVectors(1'b1, NRND, 1'b1, 20, -1);
        checkDoneOutputs("rnd_done", NRND);

        $display("[TB] random restart from DONE");
        applyStimulus(1'b1, 1'b1, 1'b1);
        runVectors(1'b1, NRND, 1'b1, -1, -1);
        checkDoneOutputs("rnd2_done", NRND);

        $display("[TB] reset mid-run");
        applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (10) tick();
        checkOutput("mid_count", vecCount, 10);
        checkOutput("mid_data",  vecData,  rndQ[10]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkIdleOutputs("midreset");
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("restart_valid", vecValid, 1'b1);
        checkOutput("restart_data",  vecData,  rndQ[0]);
        checkOutput("restart_count", vecCount, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
